// File: rtl/icache_dm_pkg.sv
// icache_dm_pkg: shared line width, NOP fill packet and refill FSM state encoding.
package icache_dm_pkg;
    localparam int ICACHE_LINE_WIDTH = 64;
    localparam logic [ICACHE_LINE_WIDTH-1:0] ICACHE_NOP_PACKET = 64'h00000013_00000013;
    typedef enum logic [1:0] {
        ICACHE_ST_IDLE = 2'd0,
        ICACHE_ST_REQ  = 2'd1,
        ICACHE_ST_WAIT = 2'd2
    } icache_state_t;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: valid/tag/data storage with async read, one write port and global valid clear.
module icache_line_array
    import icache_dm_pkg::*;
#(
    parameter int LINES = 64,
    parameter int TAG_W = 23,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clr_all,
    input  logic                         i_we,
    input  logic [IDX_W-1:0]             i_wr_idx,
    input  logic [TAG_W-1:0]             i_wr_tag,
    input  logic [ICACHE_LINE_WIDTH-1:0] i_wr_data,
    input  logic [IDX_W-1:0]             i_rd_idx,
    output logic                         o_rd_valid,
    output logic [TAG_W-1:0]             o_rd_tag,
    output logic [ICACHE_LINE_WIDTH-1:0] o_rd_data
);
    logic [LINES-1:0]             r_valid;
    logic [TAG_W-1:0]             r_tag  [LINES];
    logic [ICACHE_LINE_WIDTH-1:0] r_data [LINES];

    // A clear dominates a same-cycle write so a fenced refill lands invalid.
    always_ff @(posedge clk) begin
        if (rst || i_clr_all) r_valid <= '0;
        else if (i_we) r_valid[i_wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with single-doubleword bus refill and fence.i.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        Fetch_NextPC,
    input  logic                         Fetch_ReqEn,
    input  logic                         Ctrl_FenceI,
    output logic [ICACHE_LINE_WIDTH-1:0] Icache_Instr,
    output logic                         Icache_InstrValid,
    output logic                         Icache_StallReq,
    output logic                         Icache_BusReq,
    output logic [ADDR_WIDTH-1:0]        Icache_BusAddr,
    input  logic                         Bus_Ready,
    input  logic                         Bus_RdValid,
    input  logic [ICACHE_LINE_WIDTH-1:0] Bus_RdData
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]                  Icache_HitCnt,
    output logic [31:0]                  Icache_MissCnt
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - 3 - IDX_W;

    icache_state_t                r_state, w_next;
    logic                         r_fence_pending;
    logic [ADDR_WIDTH-1:0]        r_miss_addr;
    logic                         w_line_valid;
    logic [TAG_W-1:0]             w_line_tag;
    logic [ICACHE_LINE_WIDTH-1:0] w_line_data;
    logic                         w_hit, w_miss_start, w_fill;

    // Fence.i in the lookup cycle suppresses the hit.
    assign w_hit = Fetch_ReqEn && !Ctrl_FenceI && r_state == ICACHE_ST_IDLE && w_line_valid
                   && w_line_tag == Fetch_NextPC[ADDR_WIDTH-1 -: TAG_W];
    assign w_miss_start = r_state == ICACHE_ST_IDLE && Fetch_ReqEn && !w_hit;
    assign w_fill = r_state == ICACHE_ST_WAIT && Bus_RdValid;

    icache_line_array #(.LINES(LINES), .TAG_W(TAG_W)) u_lines (
        .clk       (clk),
        .rst       (rst),
        .i_clr_all (Ctrl_FenceI || (w_fill && r_fence_pending)),
        .i_we      (w_fill),
        .i_wr_idx  (r_miss_addr[3 +: IDX_W]),
        .i_wr_tag  (r_miss_addr[ADDR_WIDTH-1 -: TAG_W]),
        .i_wr_data (Bus_RdData),
        .i_rd_idx  (Fetch_NextPC[3 +: IDX_W]),
        .o_rd_valid(w_line_valid),
        .o_rd_tag  (w_line_tag),
        .o_rd_data (w_line_data)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ICACHE_ST_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == ICACHE_ST_IDLE ? (w_miss_start ? ICACHE_ST_REQ : ICACHE_ST_IDLE) :
                 r_state == ICACHE_ST_REQ  ? (Bus_Ready ? ICACHE_ST_WAIT : ICACHE_ST_REQ) :
                 r_state == ICACHE_ST_WAIT ? (Bus_RdValid ? ICACHE_ST_IDLE : ICACHE_ST_WAIT) :
                 ICACHE_ST_IDLE;
    end

    always_comb begin
        Icache_Instr      = w_hit ? w_line_data : ICACHE_NOP_PACKET;
        Icache_InstrValid = w_hit;
        Icache_StallReq   = r_state != ICACHE_ST_IDLE || (Fetch_ReqEn && !w_hit) || Ctrl_FenceI;
        Icache_BusReq     = r_state == ICACHE_ST_REQ;
        Icache_BusAddr    = r_miss_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) r_miss_addr <= '0;
        else if (w_miss_start) r_miss_addr <= Fetch_NextPC & ~ADDR_WIDTH'(7);
    end

    always_ff @(posedge clk) begin
        if (rst || w_fill) r_fence_pending <= 1'b0;
        else if (Ctrl_FenceI && r_state != ICACHE_ST_IDLE) r_fence_pending <= 1'b1;
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            Icache_HitCnt  <= '0;
            Icache_MissCnt <= '0;
        end else begin
            Icache_HitCnt  <= Icache_HitCnt + 32'(w_hit);
            Icache_MissCnt <= Icache_MissCnt + 32'(w_miss_start);
        end
    end
`endif
endmodule
